// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bus between a conversion requester and bin_to_bcd_seq.
// The master drives start/bin; the converter drives busy/done/bcd/overflow.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (code 4'hF) on the final write.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    bin_to_bcd_seq_if.slave        bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0]      MAX_VAL   = pow10(DIGITS) - 64'd1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    // Per-digit correction; digits are independent, no carry between them.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Digit 0 is never blanked so a zero value still shows a single 0.
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = s;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (s[4*i +: 4] == 4'd0)) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t             state_q,    state_d;
    logic [BIN_W-1:0]   shift_q,    shift_d;
    logic [BCD_W-1:0]   scratch_q,  scratch_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               ovf_q,      ovf_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [BCD_W-1:0]   bcd_q,      bcd_d;
    logic               overflow_q, overflow_d;

    logic [BCD_W-1:0]   adj_s;
    logic [BCD_W-1:0]   next_scratch_s;
    logic [BCD_W-1:0]   final_s;

    // One conversion iteration: correct the digits, then shift in the next binary MSB.
    always_comb begin
        adj_s          = add3_digits(scratch_q);
        next_scratch_s = {adj_s[BCD_W-2:0], shift_q[BIN_W-1]};
`ifdef LEADING_ZERO_BLANK_EN
        final_s        = blank_leading(next_scratch_s);
`else
        final_s        = next_scratch_s;
`endif
    end

    // Next-state and next-output logic for the IDLE/CONV controller.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_CONV;
                    shift_d   = bus.bin;
                    scratch_d = {BCD_W{1'b0}};
                    cnt_d     = {CNT_W{1'b0}};
                    ovf_d     = (64'(bus.bin) > MAX_VAL);
                    busy_d    = 1'b1;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            S_CONV: begin
                scratch_d = next_scratch_s;
                shift_d   = {shift_q[BIN_W-2:0], 1'b0};
                cnt_d     = cnt_q + CNT_W'(1);
                // The last iteration publishes the result in the same edge, so done lands BIN_W cycles after accept.
                if (cnt_q == LAST_ITER) begin
                    state_d    = S_IDLE;
                    cnt_d      = {CNT_W{1'b0}};
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    overflow_d = ovf_q;
                    bcd_d      = ovf_q ? {BCD_W{1'b1}} : final_s;
                end else begin
                    busy_d     = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion without a done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= {BIN_W{1'b0}};
            scratch_q  <= {BCD_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= {BCD_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed and random conversions against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.BIN_W(14), .DIGITS(4)) bus_if ();

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int          tests = 0;
    int          fails = 0;
    logic [15:0] held_bcd;
    logic        held_ovf;

    // Reference: decimal digits by division; blank code above the top significant digit if enabled.
    function automatic logic [15:0] exp_bcd(input int v);
        logic [15:0] r;
        int          x;
        int          nd;
        if (v > 9999) return 16'hFFFF;
        r = 16'h0000;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        nd = (v >= 1000) ? 4 : (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
        for (int i = nd; i < 4; i++) r[4*i +: 4] = 4'hF;
`else
        nd = 0;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One conversion; optionally pulses start (bin=42) while busy at cycle ign_cyc.
    task automatic run_conv(input int v, input int ign_cyc);
        int   cyc;
        logic got;
        logic stable;
        bus_if.start = 1'b1;
        bus_if.bin   = 14'(v);
        step();
        check("accept_busy", 32'(bus_if.busy), 32'd1);
        check("accept_done", 32'(bus_if.done), 32'd0);
        bus_if.start = 1'b0;
        bus_if.bin   = 14'($urandom);
        cyc    = 0;
        got    = 1'b0;
        stable = 1'b1;
        while (!got && cyc < 20) begin
            bus_if.start = (cyc == ign_cyc);
            if (cyc == ign_cyc) bus_if.bin = 14'd42;
            step();
            cyc++;
            if (bus_if.done === 1'b1) got = 1'b1;
            else if (bus_if.busy !== 1'b1 || bus_if.bcd !== held_bcd || bus_if.overflow !== held_ovf) stable = 1'b0;
        end
        bus_if.start = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(cyc), 32'd14);
        check("bcd", 32'(bus_if.bcd), 32'(exp_bcd(v)));
        check("overflow", 32'(bus_if.overflow), 32'(v > 9999));
        check("busy_at_done", 32'(bus_if.busy), 32'd0);
        check("held_while_busy", 32'(stable), 32'd1);
        held_bcd = exp_bcd(v);
        held_ovf = (v > 9999);
        step();
        check("done_pulse", 32'(bus_if.done), 32'd0);
        check("no_queue", 32'(bus_if.busy), 32'd0);
        check("bcd_hold", 32'(bus_if.bcd), 32'(held_bcd));
    endtask

    initial begin
        int   dir[11] = '{1234, 9999, 0, 7, 10000, 16383, 1, 10, 100, 1000, 999};
        int   v;
        int   k;
        int   cyc;
        logic saw;

        rst          = 1'b1;
        bus_if.start = 1'b0;
        bus_if.bin   = 14'd0;
        held_bcd     = 16'h0000;
        held_ovf     = 1'b0;
        #2;
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_bcd", 32'(bus_if.bcd), 32'd0);
        check("rst_ovf", 32'(bus_if.overflow), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        foreach (dir[i]) run_conv(dir[i], -1);

        for (int i = 0; i < 24; i++) begin
            v = (i % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
            run_conv(v, -1);
        end

        // Start pulse mid-conversion must be dropped.
        run_conv(1234, 5);

        // Asynchronous reset during a conversion: outputs clear at once, no done follows.
        bus_if.start = 1'b1;
        bus_if.bin   = 14'd4321;
        step();
        bus_if.start = 1'b0;
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus_if.busy), 32'd0);
        check("midrst_done", 32'(bus_if.done), 32'd0);
        check("midrst_bcd", 32'(bus_if.bcd), 32'd0);
        check("midrst_ovf", 32'(bus_if.overflow), 32'd0);
        step();
        rst = 1'b0;
        held_bcd = 16'h0000;
        held_ovf = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            step();
            if (bus_if.done === 1'b1) saw = 1'b1;
        end
        check("midrst_no_done", 32'(saw), 32'd0);
        check("midrst_bcd_hold", 32'(bus_if.bcd), 32'd0);

        // Back-to-back: start held high, bin stepping 0..20.
        bus_if.start = 1'b1;
        bus_if.bin   = 14'd0;
        step();
        bus_if.bin = 14'd1;
        k   = 0;
        cyc = 0;
        for (int n = 0; n < 400 && k < 21; n++) begin
            step();
            cyc++;
            if (cyc == 1 && k > 0) bus_if.bin = 14'(k + 1);
            if (bus_if.done === 1'b1) begin
                check("b2b_bcd", 32'(bus_if.bcd), 32'(exp_bcd(k)));
                check("b2b_gap", 32'(cyc), (k == 0) ? 32'd14 : 32'd15);
                k++;
                cyc = 0;
                if (k == 21) bus_if.start = 1'b0;
            end
        end
        bus_if.start = 1'b0;
        check("b2b_count", 32'(k), 32'd21);
        step();
        check("b2b_idle", 32'(bus_if.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
